// File: rtl/sram_march_tester_pkg.sv
// Shared definitions for the SRAM March C- tester: FSM encoding, element table, RAM op codes.
package sram_march_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [2:0] ELEM_LAST = 3'd5;

  // One March element: walk direction, read/write background select, which ops it contains.
  typedef struct packed {
    logic down;
    logic rd_bg1;
    logic wr_bg1;
    logic has_rd;
    logic has_wr;
  } elem_t;

  // March C-: E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 up r0
  function automatic elem_t elem_info(input logic [2:0] el);
    case (el)
      3'd0:    elem_info = '{down: 1'b0, rd_bg1: 1'b0, wr_bg1: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
      3'd1:    elem_info = '{down: 1'b0, rd_bg1: 1'b0, wr_bg1: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
      3'd2:    elem_info = '{down: 1'b0, rd_bg1: 1'b1, wr_bg1: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
      3'd3:    elem_info = '{down: 1'b1, rd_bg1: 1'b0, wr_bg1: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
      3'd4:    elem_info = '{down: 1'b1, rd_bg1: 1'b1, wr_bg1: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
      3'd5:    elem_info = '{down: 1'b0, rd_bg1: 1'b0, wr_bg1: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
      default: elem_info = '{down: 1'b0, rd_bg1: 1'b0, wr_bg1: 1'b0, has_rd: 1'b0, has_wr: 1'b0};
    endcase
  endfunction

  function automatic logic elem_is_down(input logic [2:0] el);
    elem_t e;
    e = elem_info(el);
    return e.down;
  endfunction

endpackage

// File: rtl/sram_march_tester_if.sv
// Single-port SRAM port: chip enable, read/write select, address, write data, registered read data.
interface sram_march_tester_if #(
  parameter int P_ADDR_W = 6,
  parameter int P_DATA_W = 8
) ();

  logic                ce;
  logic                rw;
  logic [P_ADDR_W-1:0] addr;
  logic [P_DATA_W-1:0] wdata;
  logic [P_DATA_W-1:0] rdata;

  modport master (output ce, output rw, output addr, output wdata, input rdata);
  modport slave  (input ce, input rw, input addr, input wdata, output rdata);

endinterface

// File: rtl/sram_march_addr_gen.sv
// Up/down address counter for the March walk: load to the element start, step, last-address flag.
module sram_march_addr_gen #(
  parameter int P_ADDR_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic                i_load_down,
  input  logic                i_step,
  input  logic                i_down,
  output logic [P_ADDR_W-1:0] o_addr,
  output logic                o_last
);

  logic [P_ADDR_W-1:0] addr_q;

  // Load wins over step; step is only requested off the last address, so the count never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      addr_q <= '0;
    else if (i_load)
      addr_q <= {P_ADDR_W{i_load_down}};
    else if (i_step)
      addr_q <= i_down ? addr_q - 1'b1 : addr_q + 1'b1;
  end

  assign o_addr = addr_q;
  assign o_last = i_down ? (addr_q == '0) : (addr_q == {P_ADDR_W{1'b1}});

endmodule

// File: rtl/sram_march_tester.sv
// March C- self-test initiator for one single-port SRAM; reports pass/fail and the first miscompare.
module sram_march_tester
  import sram_march_tester_pkg::*;
#(
  parameter int                  P_ADDR_W = 6,
  parameter int                  P_DATA_W = 8,
  parameter logic [P_DATA_W-1:0] P_BG     = 8'h55
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [P_ADDR_W-1:0] o_fail_addr,
  output logic [P_DATA_W-1:0] o_fail_exp,
  output logic [P_DATA_W-1:0] o_fail_got,
  sram_march_tester_if.master ram
);

  function automatic logic [P_DATA_W-1:0] bg(input logic one);
    return one ? ~P_BG : P_BG;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          el_q, el_d;
  logic                ph_q, ph_d;        // 1 = write half of an r,w pair
  elem_t               info;
  logic                is_rd;
  logic                mis;
  logic                ag_load, ag_load_down, ag_step, ag_last;
  logic [P_ADDR_W-1:0] ag_addr;
  logic                ce_c, rw_c;
  logic [P_ADDR_W-1:0] addr_c;
  logic [P_DATA_W-1:0] wdata_c;
  logic                rd_vld_p1;
  logic [P_DATA_W-1:0] rd_exp_p1;
  logic [P_ADDR_W-1:0] rd_addr_p1;

  assign info  = elem_info(el_q);
  assign is_rd = info.has_rd && !ph_q;
  // Read data arrives one cycle after the read; compare it against the background captured then.
  assign mis   = rd_vld_p1 && (ram.rdata != rd_exp_p1);

  sram_march_addr_gen #(.P_ADDR_W(P_ADDR_W)) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (ag_load),
    .i_load_down (ag_load_down),
    .i_step      (ag_step),
    .i_down      (info.down),
    .o_addr      (ag_addr),
    .o_last      (ag_last)
  );

  // Next-state and RAM op decode; a miscompare kills the op in the same cycle and aborts.
  always_comb begin
    state_d      = state_q;
    el_d         = el_q;
    ph_d         = ph_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    ce_c         = 1'b0;
    rw_c         = RW_WRITE;
    addr_c       = '0;
    wdata_c      = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d      = ST_RUN;
          el_d         = 3'd0;
          ph_d         = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = elem_is_down(3'd0);
        end
      end
      ST_RUN: begin
        if (mis) begin
          state_d = ST_DONE;
        end else begin
          ce_c   = 1'b1;
          addr_c = ag_addr;
          if (is_rd) begin
            rw_c = RW_READ;
          end else begin
            rw_c    = RW_WRITE;
            wdata_c = bg(info.wr_bg1);
          end
          if (is_rd && info.has_wr) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (ag_last) begin
              if (el_q == ELEM_LAST) begin
                state_d = ST_CHECK;
              end else begin
                el_d         = el_q + 3'd1;
                ag_load      = 1'b1;
                ag_load_down = elem_is_down(el_q + 3'd1);
              end
            end else begin
              ag_step = 1'b1;
            end
          end
        end
      end
      ST_CHECK: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM, element/phase counters and read-valid pipeline flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      el_q      <= 3'd0;
      ph_q      <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      el_q      <= el_d;
      ph_q      <= ph_d;
      rd_vld_p1 <= ce_c && (rw_c == RW_READ);
    end
  end

  // ---- stage p1: expected data and address of the read issued last cycle
  always_ff @(posedge i_clk) begin
    rd_exp_p1  <= bg(info.rd_bg1);
    rd_addr_p1 <= ag_addr;
  end

  // Status: cleared on start, first miscompare captured, pass set on clean completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pass      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_exp  <= '0;
      o_fail_got  <= '0;
    end else if (state_q == ST_IDLE || state_q == ST_DONE) begin
      if (i_start) begin
        o_pass      <= 1'b0;
        o_fail_addr <= '0;
        o_fail_exp  <= '0;
        o_fail_got  <= '0;
      end
    end else if (mis) begin
      o_pass      <= 1'b0;
      o_fail_addr <= rd_addr_p1;
      o_fail_exp  <= rd_exp_p1;
      o_fail_got  <= ram.rdata;
    end else if (state_d == ST_DONE) begin
      o_pass <= 1'b1;
    end
  end

  assign o_busy    = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign o_done    = (state_q == ST_DONE);
  assign ram.ce    = ce_c;
  assign ram.rw    = rw_c;
  assign ram.addr  = addr_c;
  assign ram.wdata = wdata_c;

endmodule

// File: tb/tb_sram_march_tester.sv
// Bench for sram_march_tester with a behavioural single-port SRAM (optional injected faults).
module tb_sram_march_tester;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;

  int   checks = 0;
  int   failures = 0;
  int   fault = 0;          // 0 none, 1 stuck-at-0 bit0 @0x05, 2 writes to 0x3F land in 0x3E
  logic mem_clr = 1'b1;
  bit   trace_on = 1'b0;
  int   n;

  logic [DW-1:0] mem [64];
  logic [14:0]   exp_q [$];   // {rw, addr, wdata}

  sram_march_tester_if #(.P_ADDR_W(AW), .P_DATA_W(DW)) ram_if ();

  sram_march_tester #(.P_ADDR_W(AW), .P_DATA_W(DW), .P_BG(8'h55)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_fail_addr (fail_addr),
    .o_fail_exp  (fail_exp),
    .o_fail_got  (fail_got),
    .ram         (ram_if)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered read data and optional faults on the write path
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (ram_if.ce) begin
      if (ram_if.rw)
        ram_if.rdata <= mem[ram_if.addr];
      else
        mem[(fault == 2 && ram_if.addr == 6'h3F) ? 6'h3E : ram_if.addr] <=
          (fault == 1 && ram_if.addr == 6'h05) ? (ram_if.wdata & 8'hFE) : ram_if.wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_op(input logic rw, input logic [5:0] a, input logic [7:0] d);
    exp_q.push_back({rw, a, d});
  endfunction

  // Expected March C- op stream for one complete run
  task automatic push_march();
    logic [7:0] wb;
    logic [5:0] a;
    for (int i = 0; i < 64; i++) push_op(1'b0, 6'(i), 8'h55);
    for (int e = 1; e <= 4; e++) begin
      wb = (e == 1 || e == 3) ? 8'hAA : 8'h55;
      for (int i = 0; i < 64; i++) begin
        a = (e >= 3) ? 6'(63 - i) : 6'(i);
        push_op(1'b1, a, 8'h00);
        push_op(1'b0, a, wb);
      end
    end
    for (int i = 0; i < 64; i++) push_op(1'b1, 6'(i), 8'h00);
  endtask

  // Scoreboard: every issued RAM op is popped and compared against the expected stream
  always @(negedge clk) begin
    if (rst_n && ram_if.ce) begin
      chk("op_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        chk("op", {ram_if.rw, ram_if.addr, ram_if.rw ? 8'h00 : ram_if.wdata}, exp_q.pop_front());
    end
  end

  // Called at the negedge of the first busy cycle; returns the number of busy cycles
  task automatic run_count(input int poke, output int cnt);
    cnt = 0;
    while (busy && cnt < LIMIT) begin
      cnt++;
      if (trace_on && cnt >= 1 && cnt <= 3)
        chk($sformatf("trace_c%0d", cnt), {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata},
            {1'b1, 1'b0, 6'(cnt - 1), 8'h55});
      if (trace_on && cnt == 65)
        chk("trace_c65", {ram_if.ce, ram_if.rw, ram_if.addr}, {1'b1, 1'b1, 6'h00});
      if (trace_on && cnt == 66)
        chk("trace_c66", {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata}, {1'b1, 1'b0, 6'h00, 8'hAA});
      if (poke > 0 && cnt == poke) start = 1'b1;
      if (poke > 0 && cnt == poke + 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic kick(input bit hold);
    @(negedge clk);
    start = 1'b1;
    push_march();
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_status", {busy, done, pass, fail_addr, fail_exp, fail_got}, 32'd0);
    chk("rst_ram", {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata}, 32'd0);
    rst_n = 1'b1;
    mem_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_status", {busy, done, ram_if.ce}, 32'd0);

    // Clean run with op trace
    trace_on = 1'b1;
    kick(1'b0);
    run_count(0, n);
    trace_on = 1'b0;
    chk("clean_busy_len", n, 641);
    chk("clean_done", {done, pass, busy, ram_if.ce}, 4'b1100);
    chk("clean_fail_addr", fail_addr, 0);
    chk("clean_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_held", {done, pass}, 2'b11);

    // Stuck-at-0 on bit0 at 0x05
    fault = 1;
    kick(1'b0);
    chk("restart_clear", {busy, done, pass}, 3'b100);
    run_count(0, n);
    chk("stuck_busy_len", n, 76);
    chk("stuck_status", {done, pass, ram_if.ce}, 3'b100);
    chk("stuck_addr", fail_addr, 6'h05);
    chk("stuck_exp", fail_exp, 8'h55);
    chk("stuck_got", fail_got, 8'h54);
    exp_q.delete();

    // Decoder alias: writes to 0x3F land in 0x3E
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    fault = 2;
    kick(1'b0);
    run_count(0, n);
    chk("alias_aborted", 32'(n < 641), 32'd1);
    chk("alias_status", {done, pass}, 2'b10);
    chk("alias_addr", 32'(fail_addr == 6'h3E || fail_addr == 6'h3F), 32'd1);
    exp_q.delete();

    // Reset in the middle of a run
    fault = 0;
    kick(1'b0);
    repeat (199) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_status", {ram_if.ce, busy, done, pass, fail_addr}, 32'd0);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run after reset, with a start pulse while busy that must be ignored
    kick(1'b0);
    run_count(100, n);
    chk("poke_busy_len", n, 641);
    chk("poke_done", {done, pass, fail_addr}, {1'b1, 1'b1, 6'h00});
    chk("poke_q_empty", exp_q.size(), 0);

    // Start held high through DONE restarts immediately
    kick(1'b1);
    run_count(0, n);
    chk("hold_busy_len", n, 641);
    chk("hold_done", {done, pass}, 2'b11);
    push_march();
    @(negedge clk);
    chk("hold_restart", {busy, done, pass, fail_addr}, {1'b1, 1'b0, 1'b0, 6'h00});
    start = 1'b0;
    run_count(0, n);
    chk("rerun_busy_len", n, 641);
    chk("rerun_done", {done, pass}, 2'b11);
    chk("rerun_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
